mii_rx_frame_monitor: RTL and testbench
=======================================

MII_RX_FRAME_MONITOR -- requirements
Module: mii_rx_frame_monitor

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum legal frame length in bytes, FCS included.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of status FIFO entries; power of two.
REQ-004 SHALL have port clk_clk, input, 1: the single clock, the MII RX clock.
REQ-005 SHALL have port reset_reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port phy_rx_d, input, 4: PHY receive nibble, low nibble first.
REQ-007 SHALL have ports phy_rx_dv and phy_rx_err, input, 1 each: PHY data-valid and receive-error.
REQ-008 SHALL have port mac_rx_d, output, 4: delayed copy of phy_rx_d toward the TSE MAC MII RX.
REQ-009 SHALL have ports mac_rx_dv and mac_rx_err, output, 1 each: delayed copies of phy_rx_dv and phy_rx_err.
REQ-010 SHALL have port sof_pulse, output, 1: one-cycle start-of-frame strobe.
REQ-011 SHALL have ports stat_valid (output, 1) and stat_ready (input, 1): status handshake.
REQ-012 SHALL have port stat_length, output, 16: frame byte count after SFD.
REQ-013 SHALL have port stat_flags, output, 4: bit0 rx_err, bit1 runt, bit2 oversize, bit3 alignment.
REQ-014 SHALL have ports frame_count (output, 32) and overflow_count (output, 16).

Function
REQ-015 SHALL pass phy_rx_d, phy_rx_dv and phy_rx_err to the mac_rx_* outputs through exactly 2 register stages, with no modification.
REQ-016 SHALL implement the FSM states IDLE, PREAMBLE, DATA and DROP.
REQ-017 IDLE: on phy_rx_dv=1 with nibble 0x5, go to PREAMBLE; on phy_rx_dv=1 with any other nibble, go to DROP.
REQ-018 PREAMBLE: nibble 0x5 stays in PREAMBLE; nibble 0xD preceded by at least one 0x5 goes to DATA; any other nibble goes to DROP; phy_rx_dv=0 goes to IDLE and pushes no status.
REQ-019 DROP: stay until phy_rx_dv=0, then go to IDLE; no status push, no frame_count change.
REQ-020 SHALL assert sof_pulse for one cycle, in the cycle after the edge that samples the SFD nibble 0xD.
REQ-021 DATA: count nibbles; length = nibbles/2, saturating at 0xFFFF.
REQ-022 DATA: any sampled phy_rx_err=1 sets sticky flag bit0 for the current frame.
REQ-023 On phy_rx_dv=0 in DATA, SHALL push {length, flags} and return to IDLE.
REQ-024 Flag rules at push: runt if length<MIN_LEN; oversize if length>MAX_LEN; alignment if the nibble count is odd.
REQ-025 frame_count SHALL increment, wrapping, on every push attempt, including a dropped one.
REQ-026 Status FIFO SHALL be first-word fall-through; stat_valid SHALL rise in the cycle after the push edge when the FIFO was empty.
REQ-027 An entry SHALL be popped on a clock edge where stat_valid=1 and stat_ready=1; stat_length and stat_flags SHALL hold stable while stat_valid=1 and stat_ready=0.
REQ-028 Push while full with a simultaneous pop: SHALL accept both.
REQ-029 Push while full without a pop: SHALL drop the new entry and increment overflow_count, saturating at 0xFFFF.
REQ-030 A new frame's preamble arriving on the cycle after the dv fall SHALL be tracked normally (inter-frame gap 0 tolerated).

Reset
REQ-031 reset_reset_n=0 SHALL asynchronously clear: FSM to IDLE, all pipeline registers to 0, mac_rx_* = 0, sof_pulse = 0, stat_valid = 0, FIFO empty, counters = 0, stat_length and stat_flags = 0.
REQ-032 If phy_rx_dv=1 at the first edge after reset release, the FSM SHALL enter DROP, so a partial frame is never reported.

Structure
REQ-033 A shared package SHALL hold: the FSM state enum, the SFD and preamble nibble constants, the stat_flags bit indices, and the status entry record type.
REQ-034 The status FIFO SHALL be one sub-module, mii_stat_fifo, parameterised by depth and entry width.

Verification
REQ-035 64-byte frame (15×0x5, 0xD, 128 nibbles) -> sof_pulse once; stat_length=64, stat_flags=0000, frame_count=1.
REQ-036 40-byte frame with phy_rx_err=1 on nibble 20 -> stat_length=40, stat_flags=0011.
REQ-037 1600-byte frame, then a frame of 129 nibbles -> first entry: length 1600, flags 0100; second entry: length 64, flags 1000.
REQ-038 stat_ready=0, six back-to-back 64-byte frames, FIFO_DEPTH=4 -> 4 entries held, overflow_count=2, frame_count=6.
REQ-039 Preamble 0x5,0x5,0x3 -> no sof_pulse, no status; mac_rx_* equal phy_rx_* delayed 2 cycles throughout.
REQ-040 Reset asserted mid-DATA and released with dv still high -> no status for that frame; the next full 64-byte frame gives length 64.

Source files
------------

// File: rtl/mii_rx_frame_monitor_pkg.sv
// Shared types and constants for the MII receive frame monitor.
package mii_rx_frame_monitor_pkg;

    localparam int unsigned NIB_W       = 4;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned FLAG_W      = 4;
    localparam int unsigned NIB_CNT_W   = LEN_W + 1;
    localparam int unsigned FRAME_CNT_W = 32;
    localparam int unsigned OVF_CNT_W   = 16;

    localparam logic [NIB_W-1:0] PRE_NIBBLE = 4'h5;
    localparam logic [NIB_W-1:0] SFD_NIBBLE = 4'hD;

    localparam int unsigned FLAG_RX_ERR   = 0;
    localparam int unsigned FLAG_RUNT     = 1;
    localparam int unsigned FLAG_OVERSIZE = 2;
    localparam int unsigned FLAG_ALIGN    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  length;
        logic [FLAG_W-1:0] flags;
    } stat_entry_t;

    localparam int unsigned STAT_W = $bits(stat_entry_t);

endpackage

// File: rtl/mii_rx_frame_monitor_if.sv
// Bundle of the PHY/MAC nibble streams and the status handshake around the monitor.
interface mii_rx_frame_monitor_if;
    import mii_rx_frame_monitor_pkg::*;

    logic [NIB_W-1:0]       phy_rx_d;
    logic                   phy_rx_dv;
    logic                   phy_rx_err;
    logic [NIB_W-1:0]       mac_rx_d;
    logic                   mac_rx_dv;
    logic                   mac_rx_err;
    logic                   sof_pulse;
    logic                   stat_valid;
    logic                   stat_ready;
    logic [LEN_W-1:0]       stat_length;
    logic [FLAG_W-1:0]      stat_flags;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic [OVF_CNT_W-1:0]   overflow_count;

    // master: PHY side plus status consumer; slave: the monitor itself
    modport master (
        output phy_rx_d, phy_rx_dv, phy_rx_err, stat_ready,
        input  mac_rx_d, mac_rx_dv, mac_rx_err, sof_pulse, stat_valid,
               stat_length, stat_flags, frame_count, overflow_count
    );

    modport slave (
        input  phy_rx_d, phy_rx_dv, phy_rx_err, stat_ready,
        output mac_rx_d, mac_rx_dv, mac_rx_err, sof_pulse, stat_valid,
               stat_length, stat_flags, frame_count, overflow_count
    );

endinterface

// File: rtl/mii_stat_fifo.sv
// First-word-fall-through status FIFO with a registered head; DEPTH must be a power of two >= 2.
module mii_stat_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic             drop_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop;
    logic             full;
    logic             push_ok;

    // Head register tracks mem[rd_ptr] or bypasses the write when the FIFO runs dry
    always_comb begin
        pop      = valid_q & ready;
        full     = (count_q == CW'(DEPTH));
        push_ok  = push & (~full | pop);
        drop_c   = push & full & ~pop;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        valid_d  = (count_d != '0);
        head_d   = head_q;
        if ((count_q - CW'(pop)) == '0) begin
            if (push_ok) head_d = wdata;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign valid = valid_q;
    assign rdata = head_q;

endmodule

// File: rtl/mii_rx_frame_monitor.sv
// Passive MII RX tap: forwards the nibble stream to the MAC and reports per-frame length/flags.
module mii_rx_frame_monitor
    import mii_rx_frame_monitor_pkg::*;
#(
    parameter int unsigned MIN_LEN    = 64,
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [NIB_W-1:0]       phy_rx_d,
    input  logic                   phy_rx_dv,
    input  logic                   phy_rx_err,
    output logic [NIB_W-1:0]       mac_rx_d,
    output logic                   mac_rx_dv,
    output logic                   mac_rx_err,
    output logic                   sof_pulse,
    output logic                   stat_valid,
    input  logic                   stat_ready,
    output logic [LEN_W-1:0]       stat_length,
    output logic [FLAG_W-1:0]      stat_flags,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [OVF_CNT_W-1:0]   overflow_count
);

    localparam int unsigned PIPE_W = NIB_W + 2;

    logic [PIPE_W-1:0]      pipe1_q, pipe2_q;
    rx_state_e              state_q, state_d;
    logic [NIB_CNT_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic                   odd_q, odd_d;
    logic                   err_q, err_d;
    logic                   sof_q, sof_d;
    logic                   armed_q, armed_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic                   push_c;
    logic                   fifo_drop_c;
    logic [LEN_W-1:0]       len_c;
    stat_entry_t            entry_c;
    logic [STAT_W-1:0]      head;

    // Two-stage transparent delay toward the MAC
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pipe1_q <= '0;
            pipe2_q <= '0;
        end else begin
            pipe1_q <= {phy_rx_d, phy_rx_dv, phy_rx_err};
            pipe2_q <= pipe1_q;
        end
    end

    assign {mac_rx_d, mac_rx_dv, mac_rx_err} = pipe2_q;

    // armed_q is low only for the first edge after reset, so a frame already in flight is dropped
    always_comb begin
        state_d   = state_q;
        nib_cnt_d = nib_cnt_q;
        odd_d     = odd_q;
        err_d     = err_q;
        sof_d     = 1'b0;
        armed_d   = 1'b1;
        push_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (phy_rx_dv)
                    state_d = (armed_q && phy_rx_d == PRE_NIBBLE) ? ST_PREAMBLE : ST_DROP;
            end
            ST_PREAMBLE: begin
                if (!phy_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (phy_rx_d == SFD_NIBBLE) begin
                    state_d   = ST_DATA;
                    sof_d     = 1'b1;
                    nib_cnt_d = '0;
                    odd_d     = 1'b0;
                    err_d     = 1'b0;
                end else if (phy_rx_d != PRE_NIBBLE) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (phy_rx_dv) begin
                    if (nib_cnt_q != '1) nib_cnt_d = nib_cnt_q + NIB_CNT_W'(1);
                    odd_d = ~odd_q;
                    err_d = err_q | phy_rx_err;
                end else begin
                    push_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!phy_rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status record for the frame ending at this edge
    always_comb begin
        len_c                           = nib_cnt_q[NIB_CNT_W-1:1];
        entry_c                         = '0;
        entry_c.length                  = len_c;
        entry_c.flags[FLAG_RX_ERR]      = err_q;
        entry_c.flags[FLAG_RUNT]        = (32'(len_c) < MIN_LEN);
        entry_c.flags[FLAG_OVERSIZE]    = (32'(len_c) > MAX_LEN);
        entry_c.flags[FLAG_ALIGN]       = odd_q;
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(push_c);
        ovf_cnt_d   = ovf_cnt_q;
        if (fifo_drop_c && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_IDLE;
            nib_cnt_q   <= '0;
            odd_q       <= 1'b0;
            err_q       <= 1'b0;
            sof_q       <= 1'b0;
            armed_q     <= 1'b0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            nib_cnt_q   <= nib_cnt_d;
            odd_q       <= odd_d;
            err_q       <= err_d;
            sof_q       <= sof_d;
            armed_q     <= armed_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    mii_stat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (STAT_W)
    ) u_stat_fifo (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .push   (push_c),
        .wdata  (entry_c),
        .ready  (stat_ready),
        .valid  (stat_valid),
        .rdata  (head),
        .drop_c (fifo_drop_c)
    );

    assign {stat_length, stat_flags} = head;
    assign sof_pulse      = sof_q;
    assign frame_count    = frame_cnt_q;
    assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_mii_rx_frame_monitor.sv
// Self-checking bench: frame table plus overflow, bad-preamble and reset corner sequences.
module tb_mii_rx_frame_monitor;
    import mii_rx_frame_monitor_pkg::*;

    typedef struct {
        int          pre;
        int          nibs;
        int          err_at;
        int          gap;
        logic [15:0] len;
        logic [3:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [15:0] len;
        logic [3:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mii_rx_frame_monitor_if bus ();

    mii_rx_frame_monitor #(
        .MIN_LEN    (64),
        .MAX_LEN    (1518),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .phy_rx_d       (bus.phy_rx_d),
        .phy_rx_dv      (bus.phy_rx_dv),
        .phy_rx_err     (bus.phy_rx_err),
        .mac_rx_d       (bus.mac_rx_d),
        .mac_rx_dv      (bus.mac_rx_dv),
        .mac_rx_err     (bus.mac_rx_err),
        .sof_pulse      (bus.sof_pulse),
        .stat_valid     (bus.stat_valid),
        .stat_ready     (bus.stat_ready),
        .stat_length    (bus.stat_length),
        .stat_flags     (bus.stat_flags),
        .frame_count    (bus.frame_count),
        .overflow_count (bus.overflow_count)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          sof_seen = 0;
    int          exp_sof = 0;
    int          exp_frames = 0;
    bit          pipe_en = 1'b0;
    int          hist_n = 0;
    logic [5:0]  h1, h2;
    exp_t        sb [$];
    exp_t        mon_e;
    vec_t        tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status scoreboard, SOF counter and 2-cycle pipeline checker, all sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.stat_valid === 1'b1 && bus.stat_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_status: got len %0d flags %b, expected no entry at %0t",
                         bus.stat_length, bus.stat_flags, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("stat_length", 32'(bus.stat_length), 32'(mon_e.len));
                chk("stat_flags", 32'(bus.stat_flags), 32'(mon_e.flags));
            end
        end
        if (bus.sof_pulse === 1'b1) sof_seen++;
        if (pipe_en) begin
            if (hist_n >= 2)
                chk("mac_pipeline", 32'({bus.mac_rx_d, bus.mac_rx_dv, bus.mac_rx_err}), 32'(h2));
            h2 = h1;
            h1 = {bus.phy_rx_d, bus.phy_rx_dv, bus.phy_rx_err};
            if (hist_n < 2) hist_n++;
        end else begin
            hist_n = 0;
        end
    end

    task automatic drive(input bit dv, input logic [3:0] d, input bit err);
        @(posedge clk);
        #1;
        bus.phy_rx_dv  = dv;
        bus.phy_rx_d   = d;
        bus.phy_rx_err = err;
    endtask

    function automatic logic [3:0] rnd_nib();
        return 4'($urandom_range(15, 0));
    endfunction

    task automatic sof_chk();
        @(negedge clk);
        chk("sof_pulse_timing", 32'(bus.sof_pulse), 32'd1);
    endtask

    task automatic send_frame(input int pre, input int nibs, input int err_at, input int gap,
                              input logic [15:0] len, input logic [3:0] flags,
                              input bit expect_push, input bit pop_at_end);
        exp_t e;
        for (int i = 0; i < pre; i++) drive(1'b1, PRE_NIBBLE, 1'b0);
        drive(1'b1, SFD_NIBBLE, 1'b0);
        for (int i = 0; i < nibs; i++) begin
            drive(1'b1, rnd_nib(), (i == err_at));
            if (i == 0) sof_chk();
        end
        drive(1'b0, 4'h0, 1'b0);
        if (pop_at_end) bus.stat_ready = 1'b1;
        exp_sof++;
        exp_frames++;
        if (expect_push) begin
            e.len   = len;
            e.flags = flags;
            sb.push_back(e);
        end
        if (nibs == 0) sof_chk();
        if (pop_at_end) begin
            @(posedge clk);
            #1;
            bus.stat_ready = 1'b0;
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || bus.stat_valid === 1'b1) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{15, 128,  -1, 3, 16'd64,   4'b0000};
        tbl[1] = '{15, 80,   20, 0, 16'd40,   4'b0011};
        tbl[2] = '{15, 3200, -1, 0, 16'd1600, 4'b0100};
        tbl[3] = '{15, 129,  -1, 2, 16'd64,   4'b1000};
        tbl[4] = '{1,  126,  -1, 0, 16'd63,   4'b0010};
        tbl[5] = '{7,  3036, -1, 1, 16'd1518, 4'b0000};
        tbl[6] = '{7,  3038, -1, 0, 16'd1519, 4'b0100};
        tbl[7] = '{7,  127,  -1, 3, 16'd63,   4'b1010};
        tbl[8] = '{7,  0,    -1, 0, 16'd0,    4'b0010};
        tbl[9] = '{7,  130, 129, 4, 16'd65,   4'b0001};

        rst_n          = 1'b0;
        bus.phy_rx_d   = 4'h0;
        bus.phy_rx_dv  = 1'b0;
        bus.phy_rx_err = 1'b0;
        bus.stat_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mac_rx_d", 32'(bus.mac_rx_d), 32'd0);
        chk("rst_mac_rx_dv", 32'(bus.mac_rx_dv), 32'd0);
        chk("rst_mac_rx_err", 32'(bus.mac_rx_err), 32'd0);
        chk("rst_sof_pulse", 32'(bus.sof_pulse), 32'd0);
        chk("rst_stat_valid", 32'(bus.stat_valid), 32'd0);
        chk("rst_stat_length", 32'(bus.stat_length), 32'd0);
        chk("rst_stat_flags", 32'(bus.stat_flags), 32'd0);
        chk("rst_frame_count", bus.frame_count, 32'd0);
        chk("rst_overflow_count", 32'(bus.overflow_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        pipe_en = 1'b1;

        // Broken preamble, aborted preamble and a frame starting mid-stream: none reported
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'h3, 1'b0);
        repeat (10) drive(1'b1, rnd_nib(), 1'($urandom_range(1, 0)));
        drive(1'b0, 4'h0, 1'b0);
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        repeat (20) drive(1'b1, rnd_nib(), 1'b0);
        repeat (4) drive(1'b0, 4'h0, 1'b0);
        chk("badpre_sof_count", 32'(sof_seen), 32'(exp_sof));
        chk("badpre_frame_count", bus.frame_count, 32'(exp_frames));
        chk("badpre_stat_valid", 32'(bus.stat_valid), 32'd0);

        foreach (tbl[i])
            send_frame(tbl[i].pre, tbl[i].nibs, tbl[i].err_at, tbl[i].gap,
                       tbl[i].len, tbl[i].flags, 1'b1, 1'b0);
        wait_drain("table_drain");
        chk("table_frame_count", bus.frame_count, 32'(exp_frames));
        chk("table_sof_count", 32'(sof_seen), 32'(exp_sof));
        chk("table_overflow_count", 32'(bus.overflow_count), 32'd0);

        // Six back-to-back frames with the consumer stalled: four held, two dropped
        @(posedge clk);
        #1;
        bus.stat_ready = 1'b0;
        for (int k = 0; k < 6; k++)
            send_frame(15, 128, -1, 0, 16'd64, 4'b0000, (k < 4), 1'b0);
        repeat (3) drive(1'b0, 4'h0, 1'b0);
        @(negedge clk);
        chk("ovf_overflow_count", 32'(bus.overflow_count), 32'd2);
        chk("ovf_frame_count", bus.frame_count, 32'(exp_frames));
        chk("ovf_stat_valid", 32'(bus.stat_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_stat_length", 32'(bus.stat_length), 32'd64);
            chk("hold_stat_flags", 32'(bus.stat_flags), 32'd0);
        end
        // Push into a full FIFO on the same edge as a pop: both accepted
        send_frame(7, 140, -1, 2, 16'd70, 4'b0000, 1'b1, 1'b1);
        @(negedge clk);
        chk("fullpop_overflow_count", 32'(bus.overflow_count), 32'd2);
        chk("fullpop_stat_valid", 32'(bus.stat_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.stat_ready = 1'b1;
        wait_drain("ovf_drain");
        chk("ovf_final_frame_count", bus.frame_count, 32'(exp_frames));

        // Reset in the middle of a frame, released while dv is still high
        pipe_en = 1'b0;
        repeat (7) drive(1'b1, PRE_NIBBLE, 1'b0);
        drive(1'b1, SFD_NIBBLE, 1'b0);
        exp_sof++;
        repeat (40) drive(1'b1, rnd_nib(), 1'b0);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.phy_rx_d = rnd_nib();
        #1;
        chk("async_rst_frame_count", bus.frame_count, 32'd0);
        chk("async_rst_overflow_count", 32'(bus.overflow_count), 32'd0);
        chk("async_rst_mac_rx_dv", 32'(bus.mac_rx_dv), 32'd0);
        exp_frames = 0;
        repeat (3) drive(1'b1, rnd_nib(), 1'b0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.phy_rx_d = PRE_NIBBLE;
        repeat (4) drive(1'b1, PRE_NIBBLE, 1'b0);
        drive(1'b1, SFD_NIBBLE, 1'b0);
        repeat (60) drive(1'b1, rnd_nib(), 1'b0);
        repeat (4) drive(1'b0, 4'h0, 1'b0);
        chk("rst_partial_frame_count", bus.frame_count, 32'd0);
        send_frame(7, 128, -1, 3, 16'd64, 4'b0000, 1'b1, 1'b0);
        wait_drain("rst_drain");
        chk("post_rst_frame_count", bus.frame_count, 32'(exp_frames));
        chk("final_sof_count", 32'(sof_seen), 32'(exp_sof));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
